// File: rtl/alarm_pkg.sv
// Shared state encoding for the alarm_ctrl lock/alarm controller.
package alarm_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    ENTRY  = 2'd2,
    ALARM  = 2'd3
  } state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button, plus a one-cycle rising-edge pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic level_o,
  output logic rise_o
);

  logic in_p0;
  logic in_p1;
  logic in_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_p0 <= 1'b0;
      in_p1 <= 1'b0;
      in_p2 <= 1'b0;
    end else begin
      in_p0 <= in;
      in_p1 <= in_p0;
      in_p2 <= in_p1;
    end
  end

  // in_p2 only remembers the previous synchronised level for edge detection
  assign level_o = in_p1;
  assign rise_o  = in_p1 & ~in_p2;

endmodule

// File: rtl/alarm_ctrl.sv
// Lock/alarm controller driving an LED bank from buttons and a code-match level.
// Define ALARM_CHASE_EN to show a rotating one-hot LED chase while in ALARM.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int NUM_LEDS     = 8,
  parameter int BLINK_HALF   = 25000000,
  parameter int ENTRY_CYCLES = 250000000,
  parameter int MAX_FAILS    = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           lock_btn,
  input  logic                           arm_btn,
  input  logic                           open,
  output logic [NUM_LEDS-1:0]            led,
  output logic                           alarm_o,
  output logic [1:0]                     state_o,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt_o
);

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int WW = (ENTRY_CYCLES > 1) ? $clog2(ENTRY_CYCLES) : 1;
  localparam int FW = $clog2(MAX_FAILS + 1);

  logic lock_lvl;
  logic lock_rise;
  logic arm_lvl;
  logic arm_rise;
  logic open_p0;
  logic open_p1;

  btn_sync_edge u_lock_sync (
    .clk     (clk),
    .rst     (rst),
    .in      (lock_btn),
    .level_o (lock_lvl),
    .rise_o  (lock_rise)
  );

  btn_sync_edge u_arm_sync (
    .clk     (clk),
    .rst     (rst),
    .in      (arm_btn),
    .level_o (arm_lvl),
    .rise_o  (arm_rise)
  );

  // open is a level, so it needs the synchroniser but no edge detector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      open_p0 <= 1'b0;
      open_p1 <= 1'b0;
    end else begin
      open_p0 <= open;
      open_p1 <= open_p0;
    end
  end

  logic [BW-1:0] blink_cnt;
  logic          blink_ph;
  logic          blink_wrap;

  assign blink_wrap = (blink_cnt == BW'(BLINK_HALF - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (blink_wrap) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  state_t        state;
  state_t        state_n;
  logic [WW-1:0] win_cnt;
  logic [WW-1:0] win_n;
  logic [FW-1:0] fail_cnt;
  logic [FW-1:0] fail_n;
  logic [FW-1:0] fail_inc;

  assign fail_inc = (fail_cnt == FW'(MAX_FAILS)) ? fail_cnt : fail_cnt + FW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      win_cnt  <= '0;
      fail_cnt <= '0;
    end else begin
      state    <= state_n;
      win_cnt  <= win_n;
      fail_cnt <= fail_n;
    end
  end

  // open beats a lock pulse, which beats window expiry
  always_comb begin
    state_n = state;
    win_n   = win_cnt;
    fail_n  = fail_cnt;
    case (state)
      IDLE: begin
        if (lock_rise) state_n = LOCKED;
      end
      LOCKED: begin
        if (arm_rise && !lock_rise) begin
          state_n = ENTRY;
          win_n   = WW'(ENTRY_CYCLES - 1);
        end
      end
      ENTRY: begin
        if (win_cnt != '0) win_n = win_cnt - WW'(1);
        if (open_p1) begin
          state_n = IDLE;
          fail_n  = '0;
        end else if (lock_rise) begin
          state_n = LOCKED;
        end else if (win_cnt == '0) begin
          fail_n  = fail_inc;
          state_n = (fail_inc == FW'(MAX_FAILS)) ? ALARM : LOCKED;
        end
      end
      ALARM: begin
        if (lock_rise && open_p1) begin
          state_n = LOCKED;
          fail_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  logic [NUM_LEDS-1:0] alarm_pat;

`ifdef ALARM_CHASE_EN
  logic [NUM_LEDS-1:0] chase;
  logic [NUM_LEDS-1:0] chase_rot;

  always_comb begin
    chase_rot = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      chase_rot[i] = chase[(i + NUM_LEDS - 1) % NUM_LEDS];
    end
  end

  // held at led[0] outside ALARM so the chase always starts from the LSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chase <= '0;
    end else if (state != ALARM) begin
      chase <= NUM_LEDS'(1);
    end else if (blink_wrap) begin
      chase <= chase_rot;
    end
  end

  assign alarm_pat = chase;
`else
  assign alarm_pat = {NUM_LEDS{blink_ph}};
`endif

  logic [NUM_LEDS-1:0] led_n;

  always_comb begin
    led_n = '0;
    case (state)
      IDLE:    led_n = '0;
      LOCKED:  led_n = NUM_LEDS'(1);
      ENTRY:   led_n = {NUM_LEDS{blink_ph}};
      ALARM:   led_n = alarm_pat;
      default: led_n = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led     <= '0;
      alarm_o <= 1'b0;
    end else begin
      led     <= led_n;
      alarm_o <= (state == ALARM);
    end
  end

  assign state_o    = state;
  assign fail_cnt_o = fail_cnt;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl against an event/deadline-based reference model.
module tb_alarm_ctrl;

  localparam int NL = 8;
  localparam int BH = 4;
  localparam int EC = 10;
  localparam int MF = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        lock_btn;
  logic        arm_btn;
  logic        open;
  logic [7:0]  led;
  logic        alarm_o;
  logic [1:0]  state_o;
  logic [1:0]  fail_cnt_o;
  logic [12:0] dut_vec;

  int n_checks = 0;
  int n_fail   = 0;

  alarm_ctrl #(
    .NUM_LEDS     (NL),
    .BLINK_HALF   (BH),
    .ENTRY_CYCLES (EC),
    .MAX_FAILS    (MF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lock_btn   (lock_btn),
    .arm_btn    (arm_btn),
    .open       (open),
    .led        (led),
    .alarm_o    (alarm_o),
    .state_o    (state_o),
    .fail_cnt_o (fail_cnt_o)
  );

  always #5 clk = ~clk;

  assign dut_vec = {state_o, fail_cnt_o, alarm_o, led};

  // Reference model: edges counted since reset release, inputs kept as full history.
  int         t;
  bit         lh[$];
  bit         ah[$];
  bit         oh[$];
  int         m_state;
  int         m_fail;
  int         m_deadline;
  int         m_alarm_e;
  logic [7:0] m_led;
  bit         m_alarm;

  function automatic bit at(input bit q[$], input int k);
    return (k >= 1) ? q[k-1] : 1'b0;
  endfunction

  function automatic logic [12:0] exp_vec();
    return {2'(m_state), 2'(m_fail), m_alarm, m_led};
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  task automatic model_reset();
    t = 0;
    lh.delete();
    ah.delete();
    oh.delete();
    m_state = 0;
    m_fail = 0;
    m_deadline = 0;
    m_alarm_e = 0;
    m_led = 8'h00;
    m_alarm = 1'b0;
  endtask

  task automatic model_edge();
    bit lp, ap, op;
    int ph;
    t++;
    lh.push_back(lock_btn);
    ah.push_back(arm_btn);
    oh.push_back(open);
    // a button seen at edge k becomes a pulse the FSM acts on at edge k+2
    lp = at(lh, t-2) && !at(lh, t-3);
    ap = at(ah, t-2) && !at(ah, t-3);
    op = at(oh, t-2);
    ph = ((t - 1) / BH) % 2;
    case (m_state)
      0: m_led = 8'h00;
      1: m_led = 8'h01;
      2: m_led = ph ? 8'hFF : 8'h00;
      default: begin
`ifdef ALARM_CHASE_EN
        m_led = 8'h01 << ((((t - 1) / BH) - (m_alarm_e / BH)) % NL);
`else
        m_led = ph ? 8'hFF : 8'h00;
`endif
      end
    endcase
    m_alarm = (m_state == 3);
    case (m_state)
      0: if (lp) m_state = 1;
      1: if (!lp && ap) begin
           m_state = 2;
           m_deadline = t + EC;
         end
      2: if (op) begin
           m_state = 0;
           m_fail = 0;
         end else if (lp) begin
           m_state = 1;
         end else if (t == m_deadline) begin
           m_fail = (m_fail + 1 > MF) ? MF : m_fail + 1;
           if (m_fail == MF) begin
             m_state = 3;
             m_alarm_e = t;
           end else begin
             m_state = 1;
           end
         end
      default: if (lp && op) begin
           m_state = 1;
           m_fail = 0;
         end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic press(input bit l, input bit a);
    lock_btn = l;
    arm_btn = a;
    tick();
    lock_btn = 1'b0;
    arm_btn = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 15; i++) begin
      lock_btn = 1'($urandom_range(0, 1));
      arm_btn = 1'($urandom_range(0, 1));
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_prelude t=%0d: dut=%h expected=%h", t, dut_vec, exp_vec());
      end
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (dut_vec !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_async: dut=%h expected=%h", dut_vec, 13'h0);
    end
    lock_btn = 1'b0;
    arm_btn = 1'b0;
    open = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (dut_vec !== 13'h0) begin
        n_fail++;
        $display("FAIL reset_hold: dut=%h expected=%h", dut_vec, 13'h0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (dut_vec !== 13'h0) begin
        n_fail++;
        $display("FAIL reset_release: dut=%h expected=%h", dut_vec, 13'h0);
      end
    end
  endtask

  task automatic test_open_window();
    press(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (state_o !== 2'd1 || led !== 8'h01) begin
      n_fail++;
      $display("FAIL open_locked: state=%0d led=%h expected state=1 led=01", state_o, led);
    end
    press(1'b0, 1'b1);
    for (int i = 0; i < 2; i++) tick();
    n_checks++;
    if (state_o !== 2'd2) begin
      n_fail++;
      $display("FAIL open_entry: state=%0d expected 2", state_o);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 4) open = 1'b1;
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL open_model t=%0d: dut=%h expected=%h", t, dut_vec, exp_vec());
      end
    end
    open = 1'b0;
    n_checks++;
    if (state_o !== 2'd0 || fail_cnt_o !== 2'd0 || led !== 8'h00) begin
      n_fail++;
      $display("FAIL open_idle: state=%0d fail=%0d led=%h expected 0/0/00", state_o, fail_cnt_o, led);
    end
  endtask

  task automatic test_expiry_alarm();
    press(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    press(1'b0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL expiry_model t=%0d: dut=%h expected=%h", t, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if (state_o !== 2'd1 || fail_cnt_o !== 2'd1) begin
      n_fail++;
      $display("FAIL expiry_first: state=%0d fail=%0d expected 1/1", state_o, fail_cnt_o);
    end
    press(1'b0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL alarm_model t=%0d: dut=%h expected=%h", t, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if (state_o !== 2'd3 || alarm_o !== 1'b1 || fail_cnt_o !== 2'd2) begin
      n_fail++;
      $display("FAIL expiry_alarm: state=%0d alarm=%0b fail=%0d expected 3/1/2", state_o, alarm_o, fail_cnt_o);
    end
  endtask

  task automatic test_alarm_exit();
    open = 1'b0;
    press(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL exit_model t=%0d: dut=%h expected=%h", t, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if (state_o !== 2'd3) begin
      n_fail++;
      $display("FAIL exit_no_open: state=%0d expected 3", state_o);
    end
    open = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    press(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    open = 1'b0;
    n_checks++;
    if (state_o !== 2'd1 || alarm_o !== 1'b0 || fail_cnt_o !== 2'd0) begin
      n_fail++;
      $display("FAIL exit_open: state=%0d alarm=%0b fail=%0d expected 1/0/0", state_o, alarm_o, fail_cnt_o);
    end
  endtask

  task automatic test_simultaneous();
    press(1'b1, 1'b1);
    for (int i = 0; i < 15; i++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL simul_locked_model t=%0d: dut=%h expected=%h", t, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if (state_o !== 2'd1) begin
      n_fail++;
      $display("FAIL simul_from_locked: state=%0d expected 1", state_o);
    end
    press(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    open = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    open = 1'b0;
    n_checks++;
    if (state_o !== 2'd0) begin
      n_fail++;
      $display("FAIL simul_to_idle: state=%0d expected 0", state_o);
    end
    press(1'b1, 1'b1);
    for (int i = 0; i < 15; i++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL simul_idle_model t=%0d: dut=%h expected=%h", t, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if (state_o !== 2'd1) begin
      n_fail++;
      $display("FAIL simul_from_idle: state=%0d expected 1", state_o);
    end
  endtask

  task automatic test_alarm_leds();
    logic [7:0] prev;
    int changes;
    press(1'b0, 1'b1);
    for (int i = 0; i < 15; i++) tick();
    press(1'b0, 1'b1);
    for (int i = 0; i < 20 && state_o !== 2'd3; i++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL leds_enter_model t=%0d: dut=%h expected=%h", t, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if (state_o !== 2'd3) begin
      n_fail++;
      $display("FAIL leds_enter_alarm: state=%0d expected 3", state_o);
    end
    tick();
`ifdef ALARM_CHASE_EN
    n_checks++;
    if (led !== 8'h01) begin
      n_fail++;
      $display("FAIL chase_start: led=%h expected 01", led);
    end
`endif
    prev = led;
    changes = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL leds_model t=%0d: dut=%h expected=%h", t, dut_vec, exp_vec());
      end
      if (led !== prev) begin
        n_checks++;
`ifdef ALARM_CHASE_EN
        if (led !== rotl8(prev)) begin
          n_fail++;
          $display("FAIL chase_step: led=%h expected %h", led, rotl8(prev));
        end
`else
        if (led !== ~prev) begin
          n_fail++;
          $display("FAIL blink_step: led=%h expected %h", led, ~prev);
        end
`endif
        prev = led;
        changes++;
      end
    end
    n_checks++;
    if (changes < 9) begin
      n_fail++;
      $display("FAIL leds_rate: changes=%0d expected at least 9", changes);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      lock_btn = ($urandom_range(0, 99) < 6);
      arm_btn = ($urandom_range(0, 99) < 10);
      if (open) open = ($urandom_range(0, 99) >= 20);
      else open = ($urandom_range(0, 99) < 2);
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_model t=%0d: dut=%h expected=%h", t, dut_vec, exp_vec());
      end
    end
    lock_btn = 1'b0;
    arm_btn = 1'b0;
    open = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    lock_btn = 1'b0;
    arm_btn = 1'b0;
    open = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    test_reset();
    test_open_window();
    test_expiry_alarm();
    test_alarm_exit();
    test_simultaneous();
    test_alarm_leds();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
